// File: rtl/bus_drvr_port_fifo.sv
// Per-driver TX/RX port queues between a processing element and one bus driver slot.
// Both queues are circular buffers with first-word fall-through heads and registered status.
module bus_drvr_port_fifo #(
  parameter int         bits      = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_push,
  input  logic [bits-1:0]            tx_data,
  output logic                       tx_full,
  output logic                       tx_ovf,
  output logic                       pndng,
  output logic [bits-1:0]            D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [bits-1:0]            D_push,
  output logic                       rx_valid,
  output logic [bits-1:0]            rx_data,
  input  logic                       rx_pop,
  output logic                       rx_drop,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // Handshake: a head word is offered while pndng/rx_valid is high and is consumed
  // on a rising edge where pop/rx_pop is also high; pop on an empty queue is a no-op.
  // A write into a full queue succeeds only when a read frees a slot on the same edge.

  // ---------------- TX queue ----------------
  logic [bits-1:0] r_tx_mem [depth];
  logic [PW-1:0]   r_tx_rd;
  logic [PW-1:0]   r_tx_wr;
  logic [CW-1:0]   r_tx_cnt;
  logic            r_tx_ovf;
  logic            w_tx_full;
  logic            w_tx_empty;
  logic            w_tx_rd_en;
  logic            w_tx_wr_en;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_rd_en = pop && !w_tx_empty;
  assign w_tx_wr_en = tx_push && (!w_tx_full || w_tx_rd_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) r_tx_mem[i] <= '0;
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_tx_wr_en) begin
        r_tx_mem[r_tx_wr] <= tx_data;
        r_tx_wr           <= r_tx_wr + PW'(1);
      end
      if (w_tx_rd_en) r_tx_rd <= r_tx_rd + PW'(1);
      case ({w_tx_wr_en, w_tx_rd_en})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      r_tx_ovf <= tx_push && !w_tx_wr_en;
    end
  end

  assign tx_full  = w_tx_full;
  assign tx_ovf   = r_tx_ovf;
  assign pndng    = !w_tx_empty;
  assign D_pop    = r_tx_mem[r_tx_rd];
  assign tx_count = r_tx_cnt;

  // ---------------- RX queue ----------------
  logic [bits-1:0] r_rx_mem [depth];
  logic [PW-1:0]   r_rx_rd;
  logic [PW-1:0]   r_rx_wr;
  logic [CW-1:0]   r_rx_cnt;
  logic            r_rx_drop;
  logic [7:0]      w_rx_dst;
  logic            w_rx_match;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic            w_rx_rd_en;
  logic            w_rx_wr_en;

  // Words for other drivers are discarded here and never count as drops.
  assign w_rx_dst   = D_push[bits-1 -: 8];
  assign w_rx_match = push && ((w_rx_dst == id) || (w_rx_dst == broadcast));
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_rd_en = rx_pop && !w_rx_empty;
  assign w_rx_wr_en = w_rx_match && (!w_rx_full || w_rx_rd_en);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) r_rx_mem[i] <= '0;
      r_rx_rd   <= '0;
      r_rx_wr   <= '0;
      r_rx_cnt  <= '0;
      r_rx_drop <= 1'b0;
    end else begin
      if (w_rx_wr_en) begin
        r_rx_mem[r_rx_wr] <= D_push;
        r_rx_wr           <= r_rx_wr + PW'(1);
      end
      if (w_rx_rd_en) r_rx_rd <= r_rx_rd + PW'(1);
      case ({w_rx_wr_en, w_rx_rd_en})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      r_rx_drop <= w_rx_match && !w_rx_wr_en;
    end
  end

  assign rx_valid = !w_rx_empty;
  assign rx_data  = r_rx_mem[r_rx_rd];
  assign rx_drop  = r_rx_drop;
  assign rx_count = r_rx_cnt;

endmodule

// File: tb/tb_bus_drvr_port_fifo.sv
// Bench for bus_drvr_port_fifo: directed scenarios plus randomized traffic against
// a queue-based reference model of both port queues.
module tb_bus_drvr_port_fifo;

  localparam int         BITS  = 32;
  localparam int         DEPTH = 4;
  localparam int         CW    = $clog2(DEPTH+1);
  localparam logic [7:0] ID    = 8'd3;
  localparam logic [7:0] BCAST = 8'hFF;

  logic            clk;
  logic            reset;
  logic            tx_push;
  logic [BITS-1:0] tx_data;
  logic            tx_full;
  logic            tx_ovf;
  logic            pndng;
  logic [BITS-1:0] D_pop;
  logic            pop;
  logic            push;
  logic [BITS-1:0] D_push;
  logic            rx_valid;
  logic [BITS-1:0] rx_data;
  logic            rx_pop;
  logic            rx_drop;
  logic [CW-1:0]   tx_count;
  logic [CW-1:0]   rx_count;

  bus_drvr_port_fifo #(
    .bits(BITS), .depth(DEPTH), .id(ID), .broadcast(BCAST)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop), .rx_drop(rx_drop),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  // Reference model state
  logic [BITS-1:0] tx_q[$];
  logic [BITS-1:0] rx_q[$];
  logic            exp_ovf;
  logic            exp_drop;
  int              n_vec;
  int              n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks / model ----------------
  task automatic idle_inputs();
    tx_push = 1'b0; tx_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rx_pop = 1'b0;
  endtask

  task automatic model_edge();
    bit tx_rd, tx_wr, rx_match, rx_rd, rx_wr;
    tx_rd    = pop && (tx_q.size() > 0);
    tx_wr    = tx_push && ((tx_q.size() < DEPTH) || tx_rd);
    exp_ovf  = tx_push && !tx_wr;
    rx_match = push && ((D_push[BITS-1:BITS-8] == ID) || (D_push[BITS-1:BITS-8] == BCAST));
    rx_rd    = rx_pop && (rx_q.size() > 0);
    rx_wr    = rx_match && ((rx_q.size() < DEPTH) || rx_rd);
    exp_drop = rx_match && !rx_wr;
    if (tx_rd) void'(tx_q.pop_front());
    if (tx_wr) tx_q.push_back(tx_data);
    if (rx_rd) void'(rx_q.pop_front());
    if (rx_wr) rx_q.push_back(D_push);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [BITS-1:0] rx_word(input logic [7:0] dst);
    return {dst, 24'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tx_q.delete(); rx_q.delete(); exp_ovf = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({pndng, rx_valid, tx_full, tx_ovf, rx_drop} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, want 00000", {pndng, rx_valid, tx_full, tx_ovf, rx_drop});
    end
    n_vec++;
    if (tx_count !== '0 || rx_count !== '0) begin
      n_err++; $display("FAIL reset_counts: got tx=%0d rx=%0d, want 0/0", tx_count, rx_count);
    end
    n_vec++;
    if ($isunknown(D_pop) || $isunknown(rx_data)) begin
      n_err++; $display("FAIL reset_xfree: got D_pop=%h rx_data=%h, want no X", D_pop, rx_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_tx_order();
    logic [BITS-1:0] w [3];
    w[0] = 32'h03000001; w[1] = 32'h05000002; w[2] = 32'h07000003;
    for (int i = 0; i < 3; i++) begin
      tx_push = 1'b1; tx_data = w[i];
      cycle();
      if (i == 0) begin
        n_vec++;
        if (pndng !== 1'b1 || D_pop !== w[0]) begin
          n_err++; $display("FAIL tx_first_visible: got pndng=%b D_pop=%h, want 1 %h", pndng, D_pop, w[0]);
        end
      end
    end
    tx_push = 1'b0;
    n_vec++;
    if (tx_count !== CW'(3)) begin
      n_err++; $display("FAIL tx_count3: got %0d, want 3", tx_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (D_pop !== w[i]) begin
        n_err++; $display("FAIL tx_order%0d: got %h, want %h", i, D_pop, w[i]);
      end
      pop = 1'b1;
      cycle();
      n_vec++;
      if (tx_count !== CW'(2 - i)) begin
        n_err++; $display("FAIL tx_count_drain%0d: got %0d, want %0d", i, tx_count, 2 - i);
      end
    end
    pop = 1'b0;
    n_vec++;
    if (pndng !== 1'b0) begin
      n_err++; $display("FAIL tx_empty_after: got pndng=%b, want 0", pndng);
    end
  endtask

  task automatic test_tx_full_wrap();
    logic [BITS-1:0] w [6];
    logic [BITS-1:0] exp_order [4];
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      tx_push = 1'b1; tx_data = w[i];
      cycle();
    end
    n_vec++;
    if (tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
      n_err++; $display("FAIL tx_full_set: got full=%b ovf=%b, want 1 0", tx_full, tx_ovf);
    end
    tx_data = w[4];
    cycle();
    n_vec++;
    if (tx_ovf !== 1'b1 || tx_count !== CW'(4)) begin
      n_err++; $display("FAIL tx_ovf_pulse: got ovf=%b count=%0d, want 1 4", tx_ovf, tx_count);
    end
    tx_data = w[5]; pop = 1'b1;
    cycle();
    tx_push = 1'b0; pop = 1'b0;
    n_vec++;
    if (tx_ovf !== 1'b0 || tx_count !== CW'(4) || tx_full !== 1'b1) begin
      n_err++; $display("FAIL tx_push_pop_full: got ovf=%b count=%0d full=%b, want 0 4 1", tx_ovf, tx_count, tx_full);
    end
    exp_order[0] = w[1]; exp_order[1] = w[2]; exp_order[2] = w[3]; exp_order[3] = w[5];
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (D_pop !== exp_order[i]) begin
        n_err++; $display("FAIL tx_wrap_order%0d: got %h, want %h", i, D_pop, exp_order[i]);
      end
      pop = 1'b1;
      cycle();
    end
    pop = 1'b0;
    n_vec++;
    if (pndng !== 1'b0 || tx_count !== '0) begin
      n_err++; $display("FAIL tx_wrap_empty: got pndng=%b count=%0d, want 0 0", pndng, tx_count);
    end
  endtask

  task automatic test_rx_filter();
    logic [BITS-1:0] w [3];
    w[0] = 32'h03AA0000; w[1] = 32'h04BB0000; w[2] = 32'hFFCC0000;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; D_push = w[i];
      cycle();
      n_vec++;
      if (rx_drop !== 1'b0) begin
        n_err++; $display("FAIL rx_filter_nodrop%0d: got %b, want 0", i, rx_drop);
      end
    end
    push = 1'b0;
    n_vec++;
    if (rx_count !== CW'(2) || rx_data !== w[0]) begin
      n_err++; $display("FAIL rx_filter_head: got count=%0d data=%h, want 2 %h", rx_count, rx_data, w[0]);
    end
    rx_pop = 1'b1;
    cycle();
    n_vec++;
    if (rx_data !== w[2] || rx_valid !== 1'b1) begin
      n_err++; $display("FAIL rx_filter_second: got valid=%b data=%h, want 1 %h", rx_valid, rx_data, w[2]);
    end
    cycle();
    rx_pop = 1'b0;
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++; $display("FAIL rx_filter_empty: got valid=%b, want 0", rx_valid);
    end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; D_push = rx_word(i[0] ? BCAST : ID);
      cycle();
    end
    D_push = rx_word(ID);
    cycle();
    n_vec++;
    if (rx_drop !== 1'b1 || rx_count !== CW'(4)) begin
      n_err++; $display("FAIL rx_drop_pulse: got drop=%b count=%0d, want 1 4", rx_drop, rx_count);
    end
    D_push = rx_word(BCAST); rx_pop = 1'b1;
    cycle();
    push = 1'b0; rx_pop = 1'b0;
    n_vec++;
    if (rx_drop !== 1'b0 || rx_count !== CW'(4)) begin
      n_err++; $display("FAIL rx_push_pop_full: got drop=%b count=%0d, want 0 4", rx_drop, rx_count);
    end
    while (rx_q.size() > 0) begin
      n_vec++;
      if (rx_data !== rx_q[0]) begin
        n_err++; $display("FAIL rx_full_order: got %h, want %h", rx_data, rx_q[0]);
      end
      rx_pop = 1'b1;
      cycle();
    end
    rx_pop = 1'b0;
  endtask

  task automatic test_empty_ops();
    logic [BITS-1:0] w;
    pop = 1'b1; rx_pop = 1'b1;
    repeat (3) cycle();
    n_vec++;
    if (tx_count !== '0 || rx_count !== '0 || tx_ovf !== 1'b0 || rx_drop !== 1'b0) begin
      n_err++; $display("FAIL empty_pop: got tx=%0d rx=%0d ovf=%b drop=%b, want 0 0 0 0", tx_count, rx_count, tx_ovf, rx_drop);
    end
    rx_pop = 1'b0;
    w = $urandom;
    tx_push = 1'b1; tx_data = w;
    cycle();
    tx_push = 1'b0; pop = 1'b0;
    n_vec++;
    if (tx_count !== CW'(1) || pndng !== 1'b1 || D_pop !== w) begin
      n_err++; $display("FAIL empty_push_pop: got count=%0d pndng=%b D_pop=%h, want 1 1 %h", tx_count, pndng, D_pop, w);
    end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [BITS-1:0] w;
    for (int i = 0; i < 2; i++) begin
      tx_push = 1'b1; tx_data = $urandom;
      push = 1'b1; D_push = rx_word(ID);
      cycle();
    end
    idle_inputs();
    n_vec++;
    if (tx_count !== CW'(2) || rx_count !== CW'(2)) begin
      n_err++; $display("FAIL areset_pre: got tx=%0d rx=%0d, want 2 2", tx_count, rx_count);
    end
    #2;
    reset = 1'b0;
    #1;
    tx_q.delete(); rx_q.delete(); exp_ovf = 0; exp_drop = 0;
    n_vec++;
    if (tx_count !== '0 || rx_count !== '0 || {pndng, rx_valid, tx_full, tx_ovf, rx_drop} !== 5'b0) begin
      n_err++; $display("FAIL areset_flush: got tx=%0d rx=%0d flags=%b, want 0 0 00000", tx_count, rx_count,
                        {pndng, rx_valid, tx_full, tx_ovf, rx_drop});
    end
    @(negedge clk);
    reset = 1'b1;
    w = $urandom;
    tx_push = 1'b1; tx_data = w;
    cycle();
    tx_push = 1'b0;
    n_vec++;
    if (tx_count !== CW'(1) || D_pop !== w) begin
      n_err++; $display("FAIL areset_resume: got count=%0d D_pop=%h, want 1 %h", tx_count, D_pop, w);
    end
    pop = 1'b1;
    cycle();
    pop = 1'b0;
  endtask

  task automatic test_random();
    int phase;
    for (int i = 0; i < 400; i++) begin
      phase   = (i / 40) % 2;
      tx_push = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      pop     = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      tx_data = $urandom;
      push    = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       D_push = rx_word(ID);
        1:       D_push = rx_word(BCAST);
        default: D_push = rx_word(8'($urandom));
      endcase
      rx_pop = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      cycle();
      n_vec++;
      if (tx_count !== CW'(tx_q.size()) || pndng !== (tx_q.size() > 0) || tx_full !== (tx_q.size() == DEPTH)) begin
        n_err++; $display("FAIL rnd_tx_status@%0d: got count=%0d pndng=%b full=%b, want count=%0d", i, tx_count, pndng, tx_full, tx_q.size());
      end
      n_vec++;
      if (rx_count !== CW'(rx_q.size()) || rx_valid !== (rx_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_rx_status@%0d: got count=%0d valid=%b, want count=%0d", i, rx_count, rx_valid, rx_q.size());
      end
      n_vec++;
      if (tx_ovf !== exp_ovf || rx_drop !== exp_drop) begin
        n_err++; $display("FAIL rnd_pulses@%0d: got ovf=%b drop=%b, want %b %b", i, tx_ovf, rx_drop, exp_ovf, exp_drop);
      end
      if (tx_q.size() > 0) begin
        n_vec++;
        if (D_pop !== tx_q[0]) begin
          n_err++; $display("FAIL rnd_D_pop@%0d: got %h, want %h", i, D_pop, tx_q[0]);
        end
      end
      if (rx_q.size() > 0) begin
        n_vec++;
        if (rx_data !== rx_q[0]) begin
          n_err++; $display("FAIL rnd_rx_data@%0d: got %h, want %h", i, rx_data, rx_q[0]);
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_tx_order();
    test_tx_full_wrap();
    test_rx_filter();
    test_rx_full();
    test_empty_ops();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_drvr_port_fifo.md
# bus_drvr_port_fifo

Per-driver port FIFO pair between a processing element and one driver slot of the parallel bus generator/arbiter. The TX queue holds words the element wants to send and presents them to the arbiter as `pndng`/`D_pop`/`pop`. The RX queue accepts words the arbiter delivers with `push`/`D_push`, keeps only those addressed to this driver or broadcast, and hands them to the element. One instance per driver per bus.

## Interface
- `bits`, 32: word width; destination ID field is `[bits-1:bits-8]`.
- `depth`, 8: entries per queue; power of two, ≥2.
- `id`, 0: 8-bit driver ID of this port.
- `broadcast`, 8'hFF: destination ID accepted by every port.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `tx_push`  in  1  element writes `tx_data` into the TX queue.
- `tx_data`  in  bits  outgoing word, destination ID in the top 8 bits.
- `tx_full`  out  1  TX queue holds `depth` words.
- `tx_ovf`  out  1  one-cycle pulse: `tx_push` dropped because the queue was full.
- `pndng`  out  1  TX queue non-empty; goes to the arbiter.
- `D_pop`  out  bits  TX head word (first-word fall-through).
- `pop`  in  1  arbiter consumes the TX head.
- `push`  in  1  arbiter delivers `D_push`.
- `D_push`  in  bits  incoming word.
- `rx_valid`  out  1  RX queue non-empty.
- `rx_data`  out  bits  RX head word (first-word fall-through).
- `rx_pop`  in  1  element consumes the RX head.
- `rx_drop`  out  1  one-cycle pulse: a matching `push` was lost because the RX queue was full.
- `tx_count`, `rx_count`  out  $clog2(depth+1)  occupancy of each queue.

## Operation
- Each queue is a circular buffer with read and write pointers of `$clog2(depth)` bits, wrapping modulo `depth`, plus an occupancy counter.
- TX write: accepted when `tx_push` is high and the queue is not full, or when it is full and `pop` is high in the same cycle. Otherwise the word is dropped and `tx_ovf` pulses.
- TX read: `pop` while `pndng`=1 advances the head. `pop` while empty is ignored and has no side effects. There is no bypass: a word pushed into an empty queue is not poppable in the same cycle.
- RX accept filter: `push` is high and `D_push[bits-1:bits-8]` equals `id` or `broadcast`. Non-matching words are discarded silently, with no pulse.
- RX write: a matching word is written when the queue is not full, or when it is full and `rx_pop` is high. Otherwise `rx_drop` pulses.
- RX read: `rx_pop` while `rx_valid`=1 advances the head. `rx_pop` while empty is ignored.
- Simultaneous accepted write and read: count is unchanged and both pointers advance.
- Counters never exceed `depth` and never go below 0.
- Data words pass through unmodified; ID bits are kept.

## Timing
- Reset values (asynchronous, while `reset`=0): pointers and counts 0; `pndng`=0, `rx_valid`=0, `tx_full`=0, `tx_ovf`=0, `rx_drop`=0. `D_pop` and `rx_data` are don't-care but must be X-free in simulation, so memory is initialised to 0.
- Reset asserted mid-operation flushes both queues immediately. Words in flight that cycle are lost.
- Write latency 1: a word accepted at edge N is visible on `pndng`/`D_pop` (or `rx_valid`/`rx_data`) after edge N.
- `pop`/`rx_pop` at edge N: the next head (or empty) is presented after edge N.
- `tx_full`, `pndng`, `rx_valid` and the counts are registered-state decodes with no combinational path from `push`/`pop` inputs.
- `tx_ovf`/`rx_drop` are registered and asserted for the cycle after the offending edge.
- Sustained throughput is 1 word/cycle per queue with concurrent push and pop.

## Test plan
- Reset, then 3 `tx_push` (0x03000001, 0x05000002, 0x07000003) → `pndng`=1 and `D_pop`=0x03000001 one cycle after the first push; three `pop`s return the words in order; `pndng`=0 after the third; `tx_count` goes 3→0.
- Fill TX (`depth`=4) and push a fifth word → `tx_full`=1, one `tx_ovf` pulse, fifth word absent. Next cycle, `tx_push`+`pop` while full → both accepted, `tx_count` stays 4, order preserved across pointer wrap.
- `id`=3: `push` 0x03AA0000, 0x04BB0000, 0xFFCC0000 → RX holds 0x03AA0000 then 0xFFCC0000; `rx_count`=2; no `rx_drop`.
- Fill RX (4 matching words) and push a fifth matching word → `rx_drop` pulse, word lost. Fifth push with `rx_pop` in the same cycle → accepted, count stays 4.
- `pop` and `rx_pop` on empty queues → counts stay 0, no pulses. Push into empty TX with `pop` in the same cycle → word retained, `tx_count`=1.
- Drop `reset` low asynchronously mid-cycle with both queues at 2 entries → all flags and counts 0 before the next clock edge; normal operation resumes after release.
